rom3_fetch_ctrl: RTL and testbench
==================================

# rom3_fetch_ctrl

Burst-read sequencer for the ROM3 weight store: 256-bit words, two banks, selected by `s`. It accepts one command at a time, carrying a bank, a base address and a beat count. It drives the ROM's enable, bank select and address for the ROM's fixed read latency, and delivers returned words on a valid/ready stream with a last flag. A credit-counted FIFO buffers returns so downstream backpressure never drops a ROM word. It sits between the layer scheduler (command side) and the PE-array weight loader (stream side).

## Interface
- `ROM_LAT`, 2, ROM read latency in cycles from `rom_ena`/`rom_address` to valid `rom_data`.
- `FIFO_DEPTH`, 4, return FIFO entries; must be ≥ `ROM_LAT`+2 (power of two).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  controller idle, command accepted on `cmd_valid & cmd_ready`.
- `cmd_bank`  in  4  ROM bank select (`s` value).
- `cmd_base_addr`  in  16  first word address.
- `cmd_len`  in  16  beats to read; 0 is legal.
- `rom_ena`  out  1  ROM enable, high only on issue cycles.
- `rom_s`  out  4  bank select, latched from `cmd_bank`.
- `rom_address`  out  16  ROM word address.
- `rom_data`  in  256  ROM read data.
- `out_valid`  out  1  stream word available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  256  stream word.
- `out_last`  out  1  final beat of the command.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, FETCH, DRAIN.
- **IDLE**
  - `cmd_ready`=1.
  - On accept, latch bank, base address and length into `addr_q` and `remain_q`.
  - If `cmd_len`=0: stay in IDLE and pulse `done` the next cycle; no ROM access, no beats.
  - Otherwise go to FETCH.
- **FETCH** issue condition: `fifo_count + inflight < FIFO_DEPTH`, both registered.
  - On issue: `rom_ena`=1, `rom_address`=`addr_q`, `addr_q`+1 (mod 2^16, wraps 0xFFFF→0x0000), `remain_q`−1.
  - When the issued beat is the last one (`remain_q`=1), go to DRAIN.
- **DRAIN**: no issues. Wait for the last beat to pop.
- **Return path**
  - A `ROM_LAT`-deep shift register of {valid, last} tracks each issue.
  - Its tail writes `rom_data` and the last flag into the FIFO.
  - `inflight` = number of set valid bits.
- **Stream side**: first-word-fall-through FIFO. Pop on `out_valid & out_ready`.
- **Completion**: pop with `out_last`=1 → `done`=1 that same cycle, state→IDLE at that edge, `cmd_ready`=1 the next cycle.
- **Protocol rules**
  - `out_data`/`out_last` hold stable while `out_valid & !out_ready`.
  - `cmd_*` is ignored outside IDLE.
- **Reset**: any cycle, including mid-burst.
  - State→IDLE, FIFO and shift register cleared, counters zeroed.
  - ROM returns already in flight are discarded.
  - Reset values: `cmd_ready`=1 after release; `rom_ena`=0, `rom_s`=0, `rom_address`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `done`=0.

## Timing
- Accept at edge 0 → first `rom_ena` in cycle 1.
- Data written to FIFO at cycle 1+`ROM_LAT` → first `out_valid` in cycle 2+`ROM_LAT` (cycle 4 at defaults).
- Throughput: with `out_ready` held high and `FIFO_DEPTH` ≥ `ROM_LAT`+2, one beat per cycle sustained, no issue bubbles.
- Backpressure: issue stalls once `fifo_count + inflight` = `FIFO_DEPTH`. It resumes the cycle after the pop that frees the credit.
- Command turnaround: `done` in cycle t → next command may be accepted in cycle t+1.
- `rom_s` changes only on command accept.

## Structure
- Shared package `rom3_pkg`:
  - `ROM3_DATA_W`=256, `ROM3_ADDR_W`=16, `ROM3_BANK_W`=4.
  - State enum {IDLE, FETCH, DRAIN}.
- Sub-module `rom3_fetch_fifo`: synchronous FWFT FIFO.
  - Width 257 (data+last), depth `FIFO_DEPTH`.
  - Exposes count, full, empty; clock and reset shared.
- Top level holds the FSM, issue counters, latency shift register and credit logic.

## Test plan
- Bank 1, base 0x0010, len 8, `out_ready`=1 → addresses 0x0010..0x0017 on 8 consecutive cycles starting cycle 1; beats on cycles 4..11; `out_last` on beat 8 only; `done` at cycle 11.
- len 0 → no `rom_ena`, no `out_valid`, `done` one cycle after accept, `cmd_ready` high throughout except the accept edge.
- Base 0xFFFE, len 4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order; data matches the ROM model.
- len 16 with `out_ready` low for cycles 3..12 → issues stop after 4 outstanding; no word lost or duplicated; all 16 beats delivered in order with `out_data` stable during stalls.
- Assert `rst` at cycle 6 of a len-10 burst → all outputs at reset values; stale returns never appear on `out_valid`; a fresh len-2 command afterwards yields exactly 2 correct beats.
- Back-to-back commands (bank 1 len 3, then bank 2 len 3, `cmd_valid` held) → second accepted the cycle after the first `done`; `rom_s` switches 1→2 on that accept.

Source files
------------

// File: rtl/rom3_pkg.sv
// Shared widths and FSM encoding for the ROM3 weight-store fetch path.
package rom3_pkg;

  localparam int unsigned ROM3_DATA_W = 256;
  localparam int unsigned ROM3_ADDR_W = 16;
  localparam int unsigned ROM3_BANK_W = 4;
  localparam int unsigned ROM3_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } rom3_state_e;

endpackage

// File: rtl/rom3_fetch_ctrl_if.sv
// Command, ROM and stream signals of the ROM3 fetch controller, bundled as one interface.
interface rom3_fetch_ctrl_if;
  import rom3_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [ROM3_BANK_W-1:0] cmd_bank;
  logic [ROM3_ADDR_W-1:0] cmd_base_addr;
  logic [ROM3_LEN_W-1:0]  cmd_len;

  logic                   rom_ena;
  logic [ROM3_BANK_W-1:0] rom_s;
  logic [ROM3_ADDR_W-1:0] rom_address;
  logic [ROM3_DATA_W-1:0] rom_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [ROM3_DATA_W-1:0] out_data;
  logic                   out_last;
  logic                   done;

  modport slave (
    input  cmd_valid, cmd_bank, cmd_base_addr, cmd_len, rom_data, out_ready,
    output cmd_ready, rom_ena, rom_s, rom_address, out_valid, out_data, out_last, done
  );

  modport master (
    output cmd_valid, cmd_bank, cmd_base_addr, cmd_len, rom_data, out_ready,
    input  cmd_ready, rom_ena, rom_s, rom_address, out_valid, out_data, out_last, done
  );

endinterface

// File: rtl/rom3_fetch_fifo.sv
// First-word-fall-through return FIFO; read data reads as zero while empty.
module rom3_fetch_fifo #(
  parameter int unsigned WIDTH = 257,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rom3_fetch_ctrl.sv
// Burst-read sequencer: issues ROM reads against FIFO credit and streams the returns.
module rom3_fetch_ctrl
  import rom3_pkg::*;
#(
  parameter int unsigned ROM_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  rom3_fetch_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  rom3_state_e            state_q, state_d;
  logic [ROM3_ADDR_W-1:0] addr_q, addr_d;
  logic [ROM3_LEN_W-1:0]  remain_q, remain_d;
  logic [ROM3_BANK_W-1:0] bank_q, bank_d;
  logic                   zdone_q, zdone_d;
  logic [ROM_LAT-1:0]     sr_vld_q, sr_vld_d;
  logic [ROM_LAT-1:0]     sr_last_q, sr_last_d;

  logic [CW-1:0]          fifo_count, inflight;
  logic [CW:0]            used;
  logic                   fifo_full, fifo_empty;
  logic [ROM3_DATA_W:0]   fifo_rd;
  logic                   accept, issue, pop, pop_last, credit_ok;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + CW'(sr_vld_q[i]);
    end
  end

  // Words still in the ROM pipe own a FIFO slot already, so the FIFO can never overflow.
  assign used      = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok = (used < (CW+1)'(FIFO_DEPTH)) && !fifo_full;

  assign accept   = (state_q == IDLE) && bus.cmd_valid;
  assign issue    = (state_q == FETCH) && credit_ok;
  assign pop      = !fifo_empty && bus.out_ready;
  assign pop_last = pop && fifo_rd[ROM3_DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && (bus.cmd_len != '0)) state_d = FETCH;
      FETCH:   if (issue && (remain_q == ROM3_LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (pop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready   = (state_q == IDLE);
    bus.rom_ena     = issue;
    bus.rom_s       = bank_q;
    bus.rom_address = addr_q;
    bus.out_valid   = !fifo_empty;
    bus.out_data    = fifo_rd[ROM3_DATA_W-1:0];
    bus.out_last    = fifo_rd[ROM3_DATA_W];
    bus.done        = pop_last || zdone_q;
  end

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    bank_d   = bank_q;
    zdone_d  = 1'b0;
    if (accept) begin
      addr_d   = bus.cmd_base_addr;
      remain_d = bus.cmd_len;
      bank_d   = bus.cmd_bank;
      zdone_d  = (bus.cmd_len == '0);
    end else if (issue) begin
      addr_d   = addr_q + 1'b1;
      remain_d = remain_q - 1'b1;
    end

    sr_vld_d  = sr_vld_q;
    sr_last_d = sr_last_q;
    for (int unsigned i = 1; i < ROM_LAT; i++) begin
      sr_vld_d[i]  = sr_vld_q[i-1];
      sr_last_d[i] = sr_last_q[i-1];
    end
    sr_vld_d[0]  = issue;
    sr_last_d[0] = issue && (remain_q == ROM3_LEN_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      remain_q  <= '0;
      bank_q    <= '0;
      zdone_q   <= 1'b0;
      sr_vld_q  <= '0;
      sr_last_q <= '0;
    end else begin
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      bank_q    <= bank_d;
      zdone_q   <= zdone_d;
      sr_vld_q  <= sr_vld_d;
      sr_last_q <= sr_last_d;
    end
  end

  rom3_fetch_fifo #(
    .WIDTH (ROM3_DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (sr_vld_q[ROM_LAT-1]),
    .wr_data_i ({sr_last_q[ROM_LAT-1], bus.rom_data}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_rom3_fetch_ctrl.sv
// Scoreboard bench for rom3_fetch_ctrl: directed commands against a latency-accurate ROM model.
module tb_rom3_fetch_ctrl;
  import rom3_pkg::*;

  localparam int unsigned ROM_LAT    = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom3_fetch_ctrl_if bus();

  rom3_fetch_ctrl #(
    .ROM_LAT    (ROM_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int iss_cnt = 0;

  function automatic logic [255:0] rom_word(input logic [3:0] b, input logic [15:0] a);
    return {4{12'hC3A, b, a, ~a, 4'h0, b, 8'h96}};
  endfunction

  // ROM model: data appears ROM_LAT cycles after the address is presented
  logic [3:0]  p_bank [ROM_LAT];
  logic [15:0] p_addr [ROM_LAT];
  always @(posedge clk) begin
    p_bank[0] <= bus.rom_s;
    p_addr[0] <= bus.rom_address;
    for (int i = 1; i < int'(ROM_LAT); i++) begin
      p_bank[i] <= p_bank[i-1];
      p_addr[i] <= p_addr[i-1];
    end
  end
  assign bus.rom_data = rom_word(p_bank[ROM_LAT-1], p_addr[ROM_LAT-1]);

  typedef struct {
    logic [3:0]  bank;
    logic [15:0] addr;
    int          cyc;
  } iss_t;

  typedef struct {
    logic [255:0] data;
    logic         last;
    int           cyc;
  } beat_t;

  iss_t  q_iss[$];
  beat_t q_beat[$];
  int    q_done[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected DUT event or timeout (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    iss_t  e;
    beat_t b;
    int    d;
    if (!rst) begin
      if (bus.rom_ena) begin
        iss_cnt++;
        if (q_iss.size() == 0) flag("unexpected_issue");
        else begin
          e = q_iss.pop_front();
          chk("iss_addr", 256'(bus.rom_address), 256'(e.addr));
          chk("iss_bank", 256'(bus.rom_s), 256'(e.bank));
          if (e.cyc >= 0) chk("iss_cycle", 256'(cyc), 256'(e.cyc));
        end
      end
      if (bus.out_valid) begin
        if (q_beat.size() == 0) flag("unexpected_beat");
        else begin
          b = q_beat[0];
          if (bus.out_ready) begin
            chk("beat_data", bus.out_data, b.data);
            chk("beat_last", 256'(bus.out_last), 256'(b.last));
            if (b.cyc >= 0) chk("beat_cycle", 256'(cyc), 256'(b.cyc));
            void'(q_beat.pop_front());
          end else begin
            chk("stall_data", bus.out_data, b.data);
            chk("stall_last", 256'(bus.out_last), 256'(b.last));
          end
        end
      end
      if (bus.done) begin
        if (q_done.size() == 0) flag("unexpected_done");
        else begin
          d = q_done.pop_front();
          if (d >= 0) chk("done_cycle", 256'(cyc), 256'(d));
        end
      end
    end
  end

  // acc returns the edge count at the accepting edge; relative cycle k then sits at cyc == acc+k-1
  task automatic send(input logic [3:0] b, input logic [15:0] base, input int len,
                      input bit timed, output int acc);
    int n;
    @(negedge clk);
    bus.cmd_valid     = 1'b1;
    bus.cmd_bank      = b;
    bus.cmd_base_addr = base;
    bus.cmd_len       = 16'(len);
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      flag("cmd_accept_timeout");
      bus.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    for (int i = 0; i < len; i++) begin
      iss_t  e;
      beat_t bt;
      e.bank  = b;
      e.addr  = 16'(base + 16'(i));
      e.cyc   = timed ? acc + i : -1;
      q_iss.push_back(e);
      bt.data = rom_word(b, e.addr);
      bt.last = (i == len - 1);
      bt.cyc  = timed ? acc + 3 + i : -1;
      q_beat.push_back(bt);
    end
    q_done.push_back(timed ? ((len == 0) ? acc : acc + 2 + len) : -1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((q_iss.size() != 0 || q_beat.size() != 0 || q_done.size() != 0) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 400) flag(nm);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_rom_ena"},   256'(bus.rom_ena), 256'(0));
    chk({nm, "_rom_s"},     256'(bus.rom_s), 256'(0));
    chk({nm, "_rom_addr"},  256'(bus.rom_address), 256'(0));
    chk({nm, "_out_valid"}, 256'(bus.out_valid), 256'(0));
    chk({nm, "_out_last"},  256'(bus.out_last), 256'(0));
    chk({nm, "_out_data"},  bus.out_data, 256'(0));
    chk({nm, "_done"},      256'(bus.done), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2, base_cnt;
    bus.cmd_valid     = 1'b0;
    bus.cmd_bank      = '0;
    bus.cmd_base_addr = '0;
    bus.cmd_len       = '0;
    bus.out_ready     = 1'b1;

    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("por_cmd_ready", 256'(bus.cmd_ready), 256'(1));

    // 8-beat burst, full throughput
    send(4'd1, 16'h0010, 8, 1'b1, acc);
    wait_idle("t1_drain");

    // zero-length command
    send(4'd2, 16'h0040, 0, 1'b1, acc);
    @(negedge clk);
    chk("len0_ready_c1", 256'(bus.cmd_ready), 256'(1));
    @(negedge clk);
    chk("len0_ready_c2", 256'(bus.cmd_ready), 256'(1));
    wait_idle("t2_drain");

    // address wrap
    send(4'd4, 16'hFFFE, 4, 1'b1, acc);
    wait_idle("t3_drain");

    // backpressure: stream stalled through relative cycle 12
    bus.out_ready = 1'b0;
    base_cnt = iss_cnt;
    send(4'd6, 16'h1234, 16, 1'b0, acc);
    while (cyc < acc + 11) @(negedge clk);
    #2 chk("bp_issue_count", 256'(iss_cnt - base_cnt), 256'(4));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle("t4_drain");

    // reset in the middle of a burst
    send(4'd3, 16'h0100, 10, 1'b0, acc);
    while (cyc < acc + 5) @(negedge clk);
    #2 rst = 1'b1;
    q_iss.delete();
    q_beat.delete();
    q_done.delete();
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("midrst_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    send(4'd5, 16'h0200, 2, 1'b1, acc);
    wait_idle("t5_drain");

    // back-to-back commands
    send(4'd1, 16'h0300, 3, 1'b1, acc1);
    send(4'd2, 16'h0400, 3, 1'b1, acc2);
    chk("b2b_accept_cycle", 256'(acc2), 256'(acc1 + 7));
    chk("b2b_rom_s", 256'(bus.rom_s), 256'(2));
    wait_idle("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
